// File: rtl/samul_pkg.sv
// Shared definitions for the sequential divider that follows the samul multiplier.
// Holds the FSM state encoding, the operand widths and the divide-by-zero quotient.
package samul_pkg;

  localparam int DIVIDEND_W = 64;
  localparam int DIVISOR_W  = 32;

  // Quotient reported when the divisor is zero: saturate to all ones.
  localparam logic [DIVIDEND_W-1:0] QUOT_DIV0 = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/samul_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits. Purely combinational.
module samul_div_step
  import samul_pkg::*;
(
  input  logic [DIVISOR_W:0]   partial,
  input  logic                 dividend_msb,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   next_partial,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] wide_divisor;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in 33 bits and the compare/subtract can never overflow.
  always_comb begin
    shifted      = {partial[DIVISOR_W-1:0], dividend_msb};
    wide_divisor = {1'b0, divisor};
    if (shifted >= wide_divisor) begin
      next_partial = shifted - wide_divisor;
      q_bit        = 1'b1;
    end else begin
      next_partial = shifted;
      q_bit        = 1'b0;
    end
  end

endmodule

// File: rtl/samul_div_sequential.sv
// Sequential 64/32 unsigned restoring divider with a fixed 64-cycle latency.
// The dividend register doubles as the quotient shift register: each step
// shifts the dividend left and drops the new quotient bit into the LSB.
// A zero divisor bypasses the iterations and completes one edge after start.
// Only DIVIDEND_W = 64 and DIVISOR_W = 32 are supported.
module samul_div_sequential #(
  parameter int DIVIDEND_W = 64,
  parameter int DIVISOR_W  = 32
) (
  input  logic                  slow_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  import samul_pkg::*;

  localparam logic [5:0] LAST_STEP = 6'd63;

  state_t state;
  state_t next_state;

  logic [DIVIDEND_W-1:0] dividend_reg;
  logic [DIVISOR_W-1:0]  divisor_reg;
  logic [DIVISOR_W:0]    partial;
  logic [5:0]            count;

  logic [DIVISOR_W:0]    step_partial;
  logic                  step_q_bit;
  logic                  accept;
  logic                  divisor_zero;
  logic                  last_step;

  samul_div_step u_step (
    .partial      (partial),
    .dividend_msb (dividend_reg[DIVIDEND_W-1]),
    .divisor      (divisor_reg),
    .next_partial (step_partial),
    .q_bit        (step_q_bit)
  );

  // Decode acceptance and completion conditions, then choose the next state.
  always_comb begin
    next_state   = state;
    accept       = 1'b0;
    divisor_zero = (divisor_reg == '0);
    last_step    = (count == LAST_STEP);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (divisor_zero || last_step) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operand capture, one restoring step per RUN cycle, and result loading.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      dividend_reg <= '0;
      divisor_reg  <= '0;
      partial      <= '0;
      count        <= '0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
    end else if (accept) begin
      dividend_reg <= dividend;
      divisor_reg  <= divisor;
      partial      <= '0;
      count        <= '0;
    end else if (state == RUN) begin
      if (divisor_zero) begin
        quotient    <= QUOT_DIV0;
        remainder   <= dividend_reg[DIVISOR_W-1:0];
        div_by_zero <= 1'b1;
      end else begin
        dividend_reg <= {dividend_reg[DIVIDEND_W-2:0], step_q_bit};
        partial      <= step_partial;
        count        <= count + 6'd1;
        if (last_step) begin
          quotient    <= {dividend_reg[DIVIDEND_W-2:0], step_q_bit};
          remainder   <= step_partial[DIVISOR_W-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_samul_div_sequential.sv
// Self-checking bench for samul_div_sequential: directed corner cases plus
// randomized operands compared against plain arithmetic division.
module tb_samul_div_sequential;

  logic        slow_clk;
  logic        rst;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int err_count;
  int check_count;
  int hold_errors;

  samul_div_sequential dut (
    .slow_clk    (slow_clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // 10 ns clock.
  initial slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present operands with start for one edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [63:0] a, input logic [31:0] b);
    @(negedge slow_clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge slow_clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done; optionally fire stray starts mid-run; watch result hold.
  task automatic waitDone(input bit jam, output int edges);
    bit          seen;
    logic [63:0] hq;
    logic [31:0] hr;
    logic        hz;
    hq = quotient;
    hr = remainder;
    hz = div_by_zero;
    seen  = 1'b0;
    edges = 0;
    while (!seen && edges < 200) begin
      @(posedge slow_clk);
      #1;
      edges++;
      if (done) begin
        seen = 1'b1;
      end else if (busy && (quotient !== hq || remainder !== hr || div_by_zero !== hz)) begin
        hold_errors++;
      end
      if (jam && !seen && (edges == 10 || edges == 40)) begin
        start    = 1'b1;
        dividend = {$urandom, $urandom};
        divisor  = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    if (!seen) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  // Check latency and results of a completed operation against arithmetic division.
  task automatic checkResult(input string tag, input logic [63:0] a, input logic [31:0] b,
                             input int edges);
    logic [63:0] exp_q;
    logic [31:0] exp_r;
    int          exp_lat;
    if (b == 32'd0) begin
      exp_q   = '1;
      exp_r   = a[31:0];
      exp_lat = 1;
    end else begin
      exp_q   = a / {32'd0, b};
      exp_r   = 32'(a % {32'd0, b});
      exp_lat = 64;
    end
    checkOutput({tag, "_latency"}, 64'(edges), 64'(exp_lat));
    checkOutput({tag, "_quotient"}, quotient, exp_q);
    checkOutput({tag, "_remainder"}, {32'd0, remainder}, {32'd0, exp_r});
    checkOutput({tag, "_div0"}, {63'd0, div_by_zero}, {63'd0, (b == 32'd0)});
    if (b != 32'd0) begin
      checkOutput({tag, "_identity"}, quotient * {32'd0, b} + {32'd0, remainder}, a);
      checkOutput({tag, "_rem_lt_div"}, {63'd0, (remainder < b)}, 64'd1);
    end
  endtask

  task automatic runOp(input string tag, input logic [63:0] a, input logic [31:0] b,
                       input bit jam, input bit check_drop);
    int edges;
    hold_errors = 0;
    applyStimulus(a, b);
    waitDone(jam, edges);
    checkResult(tag, a, b, edges);
    checkOutput({tag, "_hold"}, 64'(hold_errors), 64'd0);
    if (check_drop) begin
      @(posedge slow_clk);
      #1;
      checkOutput({tag, "_done_drop"}, {62'd0, done, busy}, 64'd0);
    end
  endtask

  initial begin
    int          edges;
    int          done_seen;
    logic [63:0] ra;
    logic [31:0] rb;

    err_count   = 0;
    check_count = 0;
    hold_errors = 0;
    rst         = 1'b1;
    start       = 1'b0;
    dividend    = '0;
    divisor     = '0;

    // Reset state
    repeat (3) @(posedge slow_clk);
    #1;
    checkOutput("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    checkOutput("rst_quotient", quotient, 64'd0);
    checkOutput("rst_remainder", {32'd0, remainder}, 64'd0);
    @(negedge slow_clk);
    rst = 1'b0;

    // Directed cases
    runOp("small", 64'd100, 32'd7, 1'b0, 1'b1);
    runOp("max", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1);
    checkOutput("max_q_const", quotient, 64'h0000_0000_FFFF_FFFF);
    runOp("div0", 64'd12345, 32'd0, 1'b0, 1'b1);
    runOp("small_after_div0", 64'd100, 32'd7, 1'b0, 1'b1);
    checkOutput("small_q_const", quotient, 64'd14);

    // Stray starts during RUN, then a new start in the DONE cycle
    runOp("jam_a", 64'd1000, 32'd3, 1'b1, 1'b0);
    start    = 1'b1;
    dividend = 64'd777;
    divisor  = 32'd5;
    @(posedge slow_clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_accept_busy", {63'd0, busy}, 64'd1);
    checkOutput("b2b_first_held", quotient, 64'd333);
    hold_errors = 0;
    waitDone(1'b0, edges);
    checkResult("b2b", 64'd777, 32'd5, edges);
    checkOutput("b2b_hold", 64'(hold_errors), 64'd0);

    // Reset in the middle of an operation
    applyStimulus(64'd5_000_000, 32'd13);
    done_seen = 0;
    repeat (30) begin
      @(posedge slow_clk);
      #1;
      if (done) done_seen++;
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    checkOutput("abort_quotient", quotient, 64'd0);
    checkOutput("abort_remainder", {32'd0, remainder}, 64'd0);
    repeat (3) begin
      @(posedge slow_clk);
      #1;
      if (done) done_seen++;
    end
    @(negedge slow_clk);
    rst = 1'b0;
    repeat (40) begin
      @(posedge slow_clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", 64'(done_seen), 64'd0);
    runOp("after_abort", 64'd9, 32'd3, 1'b0, 1'b1);

    // Randomized operands, mixing multiplier products and raw 64-bit values
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) ra = {32'd0, $urandom} * {32'd0, $urandom};
      else                           ra = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      runOp("rand", ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0));
    end

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule

// File: doc/samul_div_sequential.md
SAMUL_DIV_SEQUENTIAL -- requirements
Module: samul_div_sequential

Interface
REQ-001 Parameter DIVIDEND_W, default 64, dividend and quotient width; this block SHALL support only 64.
REQ-002 Parameter DIVISOR_W, default 32, divisor and remainder width; this block SHALL support only 32.
REQ-003 slow_clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request pulse; operands SHALL be sampled with it.
REQ-006 dividend  input  64  unsigned dividend (the multiplier's product format).
REQ-007 divisor  input  32  unsigned divisor.
REQ-008 busy  output  1  high while the FSM is in RUN.
REQ-009 done  output  1  single-cycle completion strobe.
REQ-010 quotient  output  64  registered unsigned quotient.
REQ-011 remainder  output  32  registered unsigned remainder.
REQ-012 div_by_zero  output  1  registered flag for the last completed operation.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE with start=1 at edge k, the block SHALL capture dividend and divisor, clear the 33-bit partial remainder, clear the 6-bit iteration count, and enter RUN.
REQ-015 start SHALL be ignored while in RUN, with no effect on the operation in progress.
REQ-016 Each RUN edge SHALL perform one restoring step, MSB first: P = {P[31:0], D[63]}; if P >= {1'b0, divisor}, then P = P - divisor and shift in q-bit 1, else shift in 0; D shifts left by one.
REQ-017 After the 64th step, at edge k+64, the block SHALL load quotient and remainder, set done=1 and enter DONE.
REQ-018 Latency SHALL be fixed at 64 edges from acceptance to done, independent of operand values.
REQ-019 DONE SHALL last exactly one cycle; without a new start it SHALL go to IDLE, and done SHALL drop.
REQ-020 A start seen in DONE SHALL be accepted in that same edge, allowing back-to-back operations every 65 cycles.
REQ-021 With divisor == 0 at acceptance, the block SHALL skip RUN: at edge k+1 it SHALL set quotient=64'hFFFF_FFFF_FFFF_FFFF, remainder=dividend[31:0], div_by_zero=1, done=1, and enter DONE.
REQ-022 div_by_zero SHALL be 0 on every non-zero-divisor completion.
REQ-023 quotient, remainder and div_by_zero SHALL hold their values until the next completion and SHALL NOT change during RUN.
REQ-024 The results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every divisor != 0.
REQ-025 The partial remainder SHALL be 33 bits wide so that no step overflows.

Reset
REQ-026 While rst=1, the FSM SHALL be in IDLE, and busy, done and div_by_zero SHALL be 0.
REQ-027 While rst=1, quotient, remainder and all internal operand, count and partial registers SHALL be 0.
REQ-028 An assertion of rst during RUN SHALL abort the operation with no done pulse; the first start accepted after release SHALL behave as after power-up.

Structure
REQ-029 A shared package samul_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE), DIVIDEND_W, DIVISOR_W and the constant QUOT_DIV0 = all ones.
REQ-030 The single restoring step SHALL be a combinational sub-module samul_div_step with inputs partial, dividend MSB and divisor, and outputs next partial and q-bit.
REQ-031 The top level SHALL contain only the FSM, the counter, the operand and result registers, and the step instance.

Verification
REQ-032 Scenario: start with dividend=100, divisor=7 -> done exactly 64 edges after acceptance; quotient=14, remainder=2, div_by_zero=0.
REQ-033 Scenario: start with dividend=64'hFFFF_FFFE_0000_0001, divisor=32'hFFFF_FFFF -> quotient=64'h0000_0000_FFFF_FFFF, remainder=0.
REQ-034 Scenario: start with dividend=12345, divisor=0 -> done at edge k+1; quotient=all ones, remainder=12345, div_by_zero=1.
REQ-035 Scenario: start pulses during RUN with other operands, and a new start in the DONE cycle -> the first result is unaffected, and the second operation completes 64 edges after its acceptance.
REQ-036 Scenario: rst asserted at step 30 of an operation -> no done pulse, all outputs 0; a fresh start with 9/3 -> quotient=3, remainder=0.
REQ-037 Scenario: 10k random operand pairs from the samul_v2 product space -> REQ-024 holds for every result; a scoreboard compares each result against a reference model.
